yd_wb_queue: RTL and testbench

//  Writeback queue on the producer side of the register file's two write ports.

---
 rtl/yd_wb_queue.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_yd_wb_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/yd_wb_queue.sv
// yd_wb_queue: writeback queue feeding the register file's two write ports.
// ALU results (A) and load results (M) are buffered in separate FIFOs and
// issued so that port writes never collide, PC writes go out alone on port 0,
// and writes to the same register from both sources retire in age order.
// Optional feature macro: YD_WB_BYPASS_EN (conflict-free writes into an empty
// FIFO skip it and load the output stage directly).
module yd_wb_queue #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_addr,
  input  logic [DW-1:0]        a_data,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_data,
  input  logic                 flush,
  output logic                 we0,
  output logic [AW-1:0]        waddr0,
  output logic [DW-1:0]        din0,
  output logic                 we1,
  output logic [AW-1:0]        waddr1,
  output logic [DW-1:0]        din1,
  output logic                 jpc,
  output logic [(1<<AW)-1:0]   pend,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(2*DEPTH) + 1;
  localparam int unsigned NR = 1 << AW;
  localparam logic [AW-1:0] ZE   = '0;
  localparam logic [AW-1:0] PC   = '1;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  // FIFO storage and pointers
  logic [AW-1:0] a_addr_q [DEPTH];
  logic [DW-1:0] a_data_q [DEPTH];
  logic [GW-1:0] a_age_q  [DEPTH];
  logic [AW-1:0] m_addr_q [DEPTH];
  logic [DW-1:0] m_data_q [DEPTH];
  logic [GW-1:0] m_age_q  [DEPTH];
  logic [PW-1:0] a_rd_q, a_rd_d, a_wr_q, a_wr_d;
  logic [PW-1:0] m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic [PW:0]   a_cnt_q, a_cnt_d, m_cnt_q, m_cnt_d;
  logic [GW-1:0] age_q, age_d;

  // Output stage
  logic          we0_q, we0_d, we1_q, we1_d, jpc_q, jpc_d;
  logic [AW-1:0] waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [DW-1:0] din0_q, din0_d, din1_q, din1_d;
  logic [NR-1:0] pend_q, pend_d;

  // Control
  logic          a_push, m_push, a_wen, m_wen, a_pop, m_pop;
  logic          a_byp, m_byp, iss_a, iss_m;
  logic          a_hv, m_hv, a_eff, m_eff, a_hpc, m_hpc, a_first;
  logic [AW-1:0] a_haddr, m_haddr;
  logic [DW-1:0] a_hdata, m_hdata;
  logic [GW-1:0] a_hage, m_hage, age_diff;

  assign a_ready = (a_cnt_q != FULL);
  assign m_ready = (m_cnt_q != FULL);
  assign a_push  = a_valid && a_ready && !flush;
  assign m_push  = m_valid && m_ready && !flush;

  assign a_hv    = (a_cnt_q != '0);
  assign m_hv    = (m_cnt_q != '0);
  assign a_haddr = a_addr_q[a_rd_q];
  assign a_hdata = a_data_q[a_rd_q];
  assign a_hage  = a_age_q[a_rd_q];
  assign m_haddr = m_addr_q[m_rd_q];
  assign m_hdata = m_data_q[m_rd_q];
  assign m_hage  = m_age_q[m_rd_q];
  assign a_eff   = a_hv && (a_haddr != ZE);
  assign m_eff   = m_hv && (m_haddr != ZE);
  assign a_hpc   = (a_haddr == PC);
  assign m_hpc   = (m_haddr == PC);
  // Wrap-safe age compare: A goes first unless M is strictly older.
  assign age_diff = m_hage - a_hage;
  assign a_first  = !age_diff[GW-1];

`ifdef YD_WB_BYPASS_EN
  logic [NR-1:0] a_mask, m_mask;
  logic          a_in_nz, m_in_nz, a_blk, m_blk;

  // Registers currently held anywhere in each FIFO (not just at the head),
  // so a bypassed write can never overtake an older queued write.
  always_comb begin
    a_mask = '0;
    m_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - a_rd_q)} < a_cnt_q) a_mask[a_addr_q[PW'(i)]] = 1'b1;
      if ({1'b0, PW'(PW'(i) - m_rd_q)} < m_cnt_q) m_mask[m_addr_q[PW'(i)]] = 1'b1;
    end
    a_mask[0] = 1'b0;
    m_mask[0] = 1'b0;
  end

  assign a_in_nz = (a_addr != ZE);
  assign m_in_nz = (m_addr != ZE);
  assign a_blk = a_in_nz && (m_mask[a_addr] || (m_hv && m_hpc) ||
                 (m_push && m_in_nz && (m_addr == a_addr || m_addr == PC)) ||
                 (a_addr == PC && (m_hv || (m_push && m_in_nz))));
  assign m_blk = m_in_nz && (a_mask[m_addr] || (a_hv && a_hpc) ||
                 (a_push && a_in_nz && (a_addr == m_addr || a_addr == PC)) ||
                 (m_addr == PC && (a_hv || (a_push && a_in_nz))));
  assign a_byp = a_push && (a_cnt_q == '0) && !a_blk;
  assign m_byp = m_push && (m_cnt_q == '0) && !m_blk;
`else
  assign a_byp = 1'b0;
  assign m_byp = 1'b0;
`endif

  assign a_wen = a_push && !a_byp;
  assign m_wen = m_push && !m_byp;

  // Head arbitration: drop zero-register heads, serialise PC and same-register pairs by age
  always_comb begin
    a_pop = a_hv && (a_haddr == ZE);
    m_pop = m_hv && (m_haddr == ZE);
    iss_a = a_eff;
    iss_m = m_eff;
    if (a_eff && m_eff && (a_hpc || m_hpc || a_haddr == m_haddr)) begin
      iss_a = a_first;
      iss_m = !a_first;
    end
    if (iss_a) a_pop = 1'b1;
    if (iss_m) m_pop = 1'b1;
  end

  // Pointer, count and age-counter next state
  always_comb begin
    a_rd_d  = a_rd_q + PW'(a_pop);
    a_wr_d  = a_wr_q + PW'(a_wen);
    a_cnt_d = a_cnt_q + (PW+1)'(a_wen) - (PW+1)'(a_pop);
    m_rd_d  = m_rd_q + PW'(m_pop);
    m_wr_d  = m_wr_q + PW'(m_wen);
    m_cnt_d = m_cnt_q + (PW+1)'(m_wen) - (PW+1)'(m_pop);
    age_d   = (a_push || m_push) ? age_q + GW'(1) : age_q;
    if (flush) begin
      a_rd_d  = '0;
      a_wr_d  = '0;
      a_cnt_d = '0;
      m_rd_d  = '0;
      m_wr_d  = '0;
      m_cnt_d = '0;
    end
  end

  // Output stage next state: issued heads first, then bypassed inputs
  always_comb begin
    we0_d    = 1'b0;
    waddr0_d = '0;
    din0_d   = '0;
    we1_d    = 1'b0;
    waddr1_d = '0;
    din1_d   = '0;
    jpc_d    = 1'b0;
    if (iss_a) begin
      we0_d    = 1'b1;
      waddr0_d = a_haddr;
      din0_d   = a_hdata;
      jpc_d    = a_hpc;
    end
    if (iss_m) begin
      if (m_hpc) begin
        we0_d    = 1'b1;
        waddr0_d = m_haddr;
        din0_d   = m_hdata;
        jpc_d    = 1'b1;
      end else begin
        we1_d    = 1'b1;
        waddr1_d = m_haddr;
        din1_d   = m_hdata;
      end
    end
    if (a_byp && a_addr != ZE) begin
      we0_d    = 1'b1;
      waddr0_d = a_addr;
      din0_d   = a_data;
      jpc_d    = (a_addr == PC);
    end
    if (m_byp && m_addr != ZE) begin
      if (m_addr == PC) begin
        we0_d    = 1'b1;
        waddr0_d = m_addr;
        din0_d   = m_data;
        jpc_d    = 1'b1;
      end else begin
        we1_d    = 1'b1;
        waddr1_d = m_addr;
        din1_d   = m_data;
      end
    end
    if (flush) begin
      we0_d = 1'b0;
      we1_d = 1'b0;
      jpc_d = 1'b0;
    end
  end

  // Scoreboard built from post-edge FIFO contents and output stage, so it
  // flags a register from the edge it is accepted until its write retires.
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - a_rd_d)} < a_cnt_d)
        pend_d[(a_wen && PW'(i) == a_wr_q) ? a_addr : a_addr_q[PW'(i)]] = 1'b1;
      if ({1'b0, PW'(PW'(i) - m_rd_d)} < m_cnt_d)
        pend_d[(m_wen && PW'(i) == m_wr_q) ? m_addr : m_addr_q[PW'(i)]] = 1'b1;
    end
    if (we0_d) pend_d[waddr0_d] = 1'b1;
    if (we1_d) pend_d[waddr1_d] = 1'b1;
    pend_d[0] = 1'b0;
    if (flush) pend_d = '0;
  end

  // FIFO storage writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_addr_q[PW'(i)] <= '0;
        a_data_q[PW'(i)] <= '0;
        a_age_q[PW'(i)]  <= '0;
        m_addr_q[PW'(i)] <= '0;
        m_data_q[PW'(i)] <= '0;
        m_age_q[PW'(i)]  <= '0;
      end
    end else begin
      if (a_wen) begin
        a_addr_q[a_wr_q] <= a_addr;
        a_data_q[a_wr_q] <= a_data;
        a_age_q[a_wr_q]  <= age_q;
      end
      if (m_wen) begin
        m_addr_q[m_wr_q] <= m_addr;
        m_data_q[m_wr_q] <= m_data;
        m_age_q[m_wr_q]  <= age_q;
      end
    end
  end

  // Control, output stage and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_q   <= '0;
      a_wr_q   <= '0;
      a_cnt_q  <= '0;
      m_rd_q   <= '0;
      m_wr_q   <= '0;
      m_cnt_q  <= '0;
      age_q    <= '0;
      we0_q    <= 1'b0;
      waddr0_q <= '0;
      din0_q   <= '0;
      we1_q    <= 1'b0;
      waddr1_q <= '0;
      din1_q   <= '0;
      jpc_q    <= 1'b0;
      pend_q   <= '0;
    end else begin
      a_rd_q   <= a_rd_d;
      a_wr_q   <= a_wr_d;
      a_cnt_q  <= a_cnt_d;
      m_rd_q   <= m_rd_d;
      m_wr_q   <= m_wr_d;
      m_cnt_q  <= m_cnt_d;
      age_q    <= age_d;
      we0_q    <= we0_d;
      waddr0_q <= waddr0_d;
      din0_q   <= din0_d;
      we1_q    <= we1_d;
      waddr1_q <= waddr1_d;
      din1_q   <= din1_d;
      jpc_q    <= jpc_d;
      pend_q   <= pend_d;
    end
  end

  assign we0    = we0_q;
  assign waddr0 = waddr0_q;
  assign din0   = din0_q;
  assign we1    = we1_q;
  assign waddr1 = waddr1_q;
  assign din1   = din1_q;
  assign jpc    = jpc_q;
  assign pend   = pend_q;
  assign busy   = (|pend_q) || (a_cnt_q != '0) || (m_cnt_q != '0);

endmodule

// File: tb/tb_yd_wb_queue.sv
// Directed bench for yd_wb_queue in its default build (2-edge write latency).
module tb_yd_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, m_valid, flush;
  logic        a_ready, m_ready;
  logic [3:0]  a_addr, m_addr;
  logic [15:0] a_data, m_data;
  logic        we0, we1, jpc, busy;
  logic [3:0]  waddr0, waddr1;
  logic [15:0] din0, din1;
  logic [15:0] pend;

  int n_tests = 0;
  int n_fail  = 0;

  yd_wb_queue #(.DW(16), .AW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .flush(flush),
    .we0(we0), .waddr0(waddr0), .din0(din0),
    .we1(we1), .waddr1(waddr1), .din1(din1),
    .jpc(jpc), .pend(pend), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    a_valid = 1'b0; m_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    #2;
    chk("rst_we0", we0, 0); chk("rst_we1", we1, 0); chk("rst_jpc", jpc, 0);
    chk("rst_pend", pend, 0); chk("rst_busy", busy, 0);
    chk("rst_aready", a_ready, 1); chk("rst_mready", m_ready, 1);
    chk("rst_waddr0", waddr0, 0); chk("rst_din1", din1, 0);
    #5 rst_n = 1'b1;

    // Single A write to R0 (reg 2)
    a_valid = 1'b1; a_addr = 4'd2; a_data = 16'h1234;
    tick(); idle_in();
    chk("t1_we0_early", we0, 0); chk("t1_pend_q", pend, 16'h0004); chk("t1_busy", busy, 1);
    tick();
    chk("t1_we0", we0, 1); chk("t1_waddr0", waddr0, 2); chk("t1_din0", din0, 16'h1234);
    chk("t1_we1", we1, 0); chk("t1_pend_o", pend, 16'h0004);
    tick();
    chk("t1_we0_off", we0, 0); chk("t1_pend_clr", pend, 0); chk("t1_busy_clr", busy, 0);

    // Simultaneous writes to different registers use both ports
    a_valid = 1'b1; a_addr = 4'd5; a_data = 16'hAAAA;
    m_valid = 1'b1; m_addr = 4'd6; m_data = 16'hBBBB;
    tick(); idle_in();
    chk("t2_pend", pend, 16'h0060);
    tick();
    chk("t2_we0", we0, 1); chk("t2_waddr0", waddr0, 5); chk("t2_din0", din0, 16'hAAAA);
    chk("t2_we1", we1, 1); chk("t2_waddr1", waddr1, 6); chk("t2_din1", din1, 16'hBBBB);
    tick();
    chk("t2_idle0", we0, 0); chk("t2_idle1", we1, 0);

    // A then M to the same register, one cycle apart
    a_valid = 1'b1; a_addr = 4'd7; a_data = 16'h1111;
    tick(); a_valid = 1'b0;
    m_valid = 1'b1; m_addr = 4'd7; m_data = 16'h2222;
    tick(); m_valid = 1'b0;
    chk("t3_we0", we0, 1); chk("t3_din0", din0, 16'h1111); chk("t3_we1_off", we1, 0);
    chk("t3_pend", pend, 16'h0080);
    tick();
    chk("t3_we0_off", we0, 0); chk("t3_we1", we1, 1);
    chk("t3_waddr1", waddr1, 7); chk("t3_din1", din1, 16'h2222);
    tick();
    chk("t3_idle", we1, 0); chk("t3_pend_clr", pend, 0);

    // Same-register tie (A first), then older M PC write blocks younger A
    a_valid = 1'b1; a_addr = 4'd12; a_data = 16'hC0C0;
    m_valid = 1'b1; m_addr = 4'd12; m_data = 16'hD0D0;
    tick(); a_valid = 1'b0;
    m_addr = 4'd15; m_data = 16'h0040;
    tick(); m_valid = 1'b0;
    chk("t4_tie_we0", we0, 1); chk("t4_tie_waddr0", waddr0, 12); chk("t4_tie_din0", din0, 16'hC0C0);
    chk("t4_tie_we1", we1, 0); chk("t4_pend1", pend, 16'h9000);
    a_valid = 1'b1; a_addr = 4'd3; a_data = 16'h7777;
    tick(); a_valid = 1'b0;
    chk("t4_m12_we1", we1, 1); chk("t4_m12_din1", din1, 16'hD0D0); chk("t4_m12_we0", we0, 0);
    chk("t4_pend2", pend, 16'h9008);
    tick();
    chk("t4_pc_we0", we0, 1); chk("t4_pc_waddr0", waddr0, 15); chk("t4_pc_din0", din0, 16'h0040);
    chk("t4_pc_jpc", jpc, 1); chk("t4_pc_we1", we1, 0); chk("t4_pend3", pend, 16'h8008);
    tick();
    chk("t4_a3_we0", we0, 1); chk("t4_a3_waddr0", waddr0, 3); chk("t4_a3_din0", din0, 16'h7777);
    chk("t4_a3_jpc", jpc, 0);
    tick();
    chk("t4_idle", we0, 0); chk("t4_pend_clr", pend, 0);

    // Zero-register write is dropped; M to DK still issues
    a_valid = 1'b1; a_addr = 4'd0; a_data = 16'hDEAD;
    m_valid = 1'b1; m_addr = 4'd1; m_data = 16'hBEEF;
    tick(); idle_in();
    chk("t7_pend", pend, 16'h0002); chk("t7_busy", busy, 1);
    tick();
    chk("t7_we0", we0, 0); chk("t7_we1", we1, 1); chk("t7_waddr1", waddr1, 1);
    chk("t7_din1", din1, 16'hBEEF);
    tick();
    chk("t7_busy_clr", busy, 0);

    // A PC write tied with an M write: PC goes alone on port 0
    a_valid = 1'b1; a_addr = 4'd15; a_data = 16'hF00D;
    m_valid = 1'b1; m_addr = 4'd5;  m_data = 16'h0505;
    tick(); idle_in();
    chk("t8_pend", pend, 16'h8020);
    tick();
    chk("t8_we0", we0, 1); chk("t8_waddr0", waddr0, 15); chk("t8_din0", din0, 16'hF00D);
    chk("t8_jpc", jpc, 1); chk("t8_we1", we1, 0);
    tick();
    chk("t8_m_we1", we1, 1); chk("t8_m_din1", din1, 16'h0505); chk("t8_m_we0", we0, 0);
    chk("t8_m_jpc", jpc, 0);
    tick();

    // Both sources hammer reg 10: A fills and blocks, then everything drains in age order
    for (int c = 0; c < 15; c++) begin
      a_valid = (c <= 7); a_addr = 4'd10; a_data = 16'hA000 + 16'(c);
      m_valid = (c <= 6); m_addr = 4'd10; m_data = 16'hB000 + 16'(c);
      tick();
      if (c >= 1 && c <= 13) begin
        if (((c - 1) % 2) == 0) begin
          chk("t5_a_we0", we0, 1); chk("t5_a_waddr0", waddr0, 10);
          chk("t5_a_din0", din0, 32'hA000 + (c - 1) / 2); chk("t5_a_we1", we1, 0);
        end else begin
          chk("t5_m_we1", we1, 1); chk("t5_m_waddr1", waddr1, 10);
          chk("t5_m_din1", din1, 32'hB000 + (c - 2) / 2); chk("t5_m_we0", we0, 0);
        end
      end
      if (c == 5) chk("t5_m_full", m_ready, 0);
      if (c == 6) chk("t5_a_full", a_ready, 0);
      if (c == 7) chk("t5_a_ready_again", a_ready, 1);
      if (c == 14) begin
        chk("t5_no_extra0", we0, 0); chk("t5_no_extra1", we1, 0);
      end
    end
    idle_in();
    tick();
    chk("t5_busy_clr", busy, 0); chk("t5_pend_clr", pend, 0);

    // Flush discards queued writes and a same-edge push
    a_valid = 1'b1; a_addr = 4'd11; a_data = 16'h1100;
    m_valid = 1'b1; m_addr = 4'd11; m_data = 16'h2200;
    tick();
    a_data = 16'h1101; m_data = 16'h2201;
    tick();
    chk("t6_we0", we0, 1); chk("t6_din0", din0, 16'h1100); chk("t6_pend", pend, 16'h0800);
    m_valid = 1'b0; a_data = 16'h1102; flush = 1'b1;
    tick(); idle_in();
    chk("t6_fl_we0", we0, 0); chk("t6_fl_we1", we1, 0); chk("t6_fl_jpc", jpc, 0);
    chk("t6_fl_pend", pend, 0); chk("t6_fl_busy", busy, 0);
    tick();
    chk("t6_post_we0", we0, 0); chk("t6_post_we1", we1, 0); chk("t6_post_busy", busy, 0);

    // Asynchronous reset mid-drain; flush while in reset is harmless
    a_valid = 1'b1; a_addr = 4'd13; a_data = 16'h1313;
    m_valid = 1'b1; m_addr = 4'd14; m_data = 16'h1414;
    tick();
    a_data = 16'h2323; m_data = 16'h2424;
    tick(); idle_in();
    chk("t9_we0", we0, 1); chk("t9_we1", we1, 1); chk("t9_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t9_ar_we0", we0, 0); chk("t9_ar_we1", we1, 0); chk("t9_ar_waddr0", waddr0, 0);
    chk("t9_ar_din1", din1, 0); chk("t9_ar_pend", pend, 0); chk("t9_ar_busy", busy, 0);
    chk("t9_ar_aready", a_ready, 1);
    flush = 1'b1;
    tick();
    chk("t9_rf_we0", we0, 0); chk("t9_rf_busy", busy, 0);
    #3 rst_n = 1'b1; flush = 1'b0;
    tick();
    chk("t9_rel_we0", we0, 0); chk("t9_rel_we1", we1, 0);
    chk("t9_rel_busy", busy, 0); chk("t9_rel_mready", m_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
